// File: rtl/run_ctrl_if.sv
// Host/core handshake bundle for the run sequencer: host request and core halt in,
// core reset/enable and run status out.
interface run_ctrl_if #(
    parameter int CW = 16
);
    logic          req;
    logic          core_halt;
    logic          core_reset;
    logic          core_run;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    modport master (
        output req, core_halt,
        input  core_reset, core_run, done, timeout, cycle_count
    );

    modport slave (
        input  req, core_halt,
        output core_reset, core_run, done, timeout, cycle_count
    );
endinterface

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset for RST_CYC cycles after a req rising edge,
// then clock-enables it until halt, watchdog expiry or host abort.
module run_ctrl #(
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0]    INIT_LOAD = 8'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [7:0]    init_q, init_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          to_q, to_d;
    logic [CW-1:0] cyc_inc;

    assign cyc_inc = cyc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        req_d   = bus.req;
        init_d  = init_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (bus.req && !req_q) begin
                    state_d = INIT;
                    init_d  = INIT_LOAD;
                    cyc_d   = '0;
                    to_d    = 1'b0;
                end
            end
            INIT: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (init_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    init_d = init_q - 8'd1;
                end
            end
            RUN: begin
                // The count advances even on the aborting cycle: that instruction did execute.
                cyc_d = cyc_inc;
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (bus.core_halt) begin
                    state_d = DONE;
                    to_d    = 1'b0;
                end else if (cyc_inc == TO_LIMIT) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_q resets high so a request held through reset cannot start a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b1;
            init_q  <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            init_q  <= init_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    assign bus.core_reset  = (state_q == IDLE) || (state_q == INIT);
    assign bus.core_run    = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.timeout     = to_q;
    assign bus.cycle_count = cyc_q;
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer for the single-cycle 9-bit core. It accepts the host `req` handshake and holds the core in reset for a fixed number of cycles. It then runs the core with a clock-enable until the core signals halt or a watchdog cycle limit expires, and reports `done`, `timeout` and the cycle count back to the host. It sits between the host/testbench `req`/`done` pins and the core's `reset` input and its PC/register/flag clock enable.

## Interface
Parameters:
- `CW`, 16, width of the run-cycle counter.
- `RST_CYC`, 2, number of cycles `core_reset` is asserted before running (legal range 1 to 255).
- `TIMEOUT`, 4096, watchdog limit in RUN cycles (legal range 1 to 2^CW-1).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  host run request (level handshake).
- `core_halt`  in  1  core has reached its end-of-program condition (combinational from the core's PC).
- `core_reset`  out  1  synchronous reset to the core.
- `core_run`  out  1  core clock enable: PC, register file, data memory write and carry-flag updates are allowed only while it is high.
- `done`  out  1  run complete; held high while `req` is held high.
- `timeout`  out  1  the last run ended on the watchdog, not on `core_halt`.
- `cycle_count`  out  CW  number of RUN cycles in the last or current run.

## Operation
- States:
  - IDLE (`core_reset`=1, `core_run`=0, `done`=0)
  - INIT (`core_reset`=1, `core_run`=0)
  - RUN (`core_reset`=0, `core_run`=1)
  - DONE (`core_reset`=0, `core_run`=0, `done`=1; the core state is frozen so the host can read it)
- `req_q` registers `req`; a start requires a rising edge, i.e. `req`=1 and `req_q`=0.
- IDLE -> INIT on a `req` rising edge.
  - In the same edge: `cycle_count` <= 0, `timeout` <= 0, and the INIT down-counter is loaded with `RST_CYC`-1.
- INIT: the down-counter decrements each cycle.
  - INIT -> RUN when the down-counter is 0, so INIT lasts exactly `RST_CYC` cycles.
  - `req`=0 in INIT -> IDLE (abort).
- RUN: every RUN cycle, `cycle_count` <= `cycle_count`+1.
  - `core_halt`=1 -> DONE, `timeout` <= 0.
  - Else if `cycle_count`+1 == `TIMEOUT` -> DONE, `timeout` <= 1.
  - Priority: `req`=0 abort (-> IDLE) beats halt; halt beats timeout.
  - On abort, `cycle_count` keeps the incremented value for that cycle, `timeout` stays 0 and `done` is never asserted.
- DONE: hold `cycle_count` and `timeout`.
  - `req`=0 -> IDLE.
  - `done` is never re-asserted without a new rising edge.
- IDLE keeps `cycle_count` and `timeout` from the last run until the next start.
- `cycle_count` arithmetic is unsigned CW-bit; it cannot exceed `TIMEOUT`, so it never wraps.
- `reset` (any state, including mid-RUN) -> IDLE with:
  - `core_reset`=1, `core_run`=0, `done`=0, `timeout`=0, `cycle_count`=0
  - `req_q`=1, so a `req` held high through reset does not start a run; `req` must go low and then high again.

## Timing
- Moore machine: all outputs are decoded from registered state and counters, with no combinational path from `req` or `core_halt` to any output.
- Edge E0 samples the `req` rise: `core_reset`=1 for cycles E0+1 .. E0+`RST_CYC`, and `core_run`=1 from cycle E0+`RST_CYC`+1.
- The core executes exactly one instruction per RUN cycle. The instruction in the cycle where `core_halt` is sampled high does execute; `core_run` drops at the next edge.
- `done` rises at the edge that samples `core_halt`=1 (or the watchdog condition), i.e. one cycle after the halting cycle begins.
- `done` falls at the first edge that samples `req`=0; `core_reset` reasserts at that same edge.
- Minimum req-to-done latency: `RST_CYC`+2 edges, when `core_halt` is high in the first RUN cycle, giving `cycle_count`=1.

## Test plan
All scenarios use `RST_CYC`=2 and `TIMEOUT`=20.
- Assert `reset` for 2 cycles -> `core_reset`=1, `core_run`=0, `done`=0, `timeout`=0, `cycle_count`=0.
- Raise `req` (low -> high) at edge 0 and pulse `core_halt` in the 5th RUN cycle -> `core_reset`=1 on cycles 1-2; `core_run`=1 on cycles 3-7; `done`=1 from edge 8 with `cycle_count`=5 and `timeout`=0. Drop `req` -> `done`=0 and `core_reset`=1 on the next cycle, while `cycle_count` stays 5.
- Start with `core_halt` never asserted -> exactly 20 RUN cycles, then `done`=1, `timeout`=1, `cycle_count`=20.
- Assert `core_halt` in the 20th RUN cycle -> `done`=1, `timeout`=0, `cycle_count`=20.
- Drop `req` during the 3rd RUN cycle -> IDLE next cycle, `core_reset`=1, `done` never high, `cycle_count`=3. Separately, drop `req` during INIT -> IDLE, `core_run` never high.
- Assert `reset` mid-RUN (`cycle_count`=7) with `req` held high -> IDLE, `cycle_count`=0, and no new run starts. Then take `req` low for 1 cycle and high again -> INIT starts on the next edge.
